n64_vinfo_deblur: RTL and testbench



---
 rtl/n64_vinfo_deblur_pkg.sv | 28 ++
 rtl/n64_vinfo_lines.sv | 64 ++++++
 rtl/n64_vinfo_deblur.sv | 125 ++++++++++++
 tb/tb_n64_vinfo_deblur.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/n64_vinfo_deblur_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// n64_vinfo_deblur_pkg: shared encodings for n64_vinfo_deblur and n64_vdemux.
// Rev 1.0
// ---------------------------------------------------------------------------
package n64_vinfo_deblur_pkg;

  localparam logic [1:0] DEBLUR_MODE_AUTO = 2'b00;
  localparam logic [1:0] DEBLUR_MODE_OFF  = 2'b01;
  localparam logic [1:0] DEBLUR_MODE_ON   = 2'b10;

  // demuxparams bit positions, shared with n64_vdemux
  localparam int DMX_CNT_MSB = 4;
  localparam int DMX_CNT_LSB = 3;
  localparam int DMX_NDEBLUR = 2;
  localparam int DMX_NBLANK  = 1;
  localparam int DMX_N15BIT  = 0;

  localparam int LINE_CNT_W = 10;

  typedef struct packed {
    logic [6:0] r;
    logic [6:0] g;
    logic [6:0] b;
  } pixel_t;

endpackage
`default_nettype wire

// File: rtl/n64_vinfo_lines.sv
`default_nettype none
// ---------------------------------------------------------------------------
// n64_vinfo_lines: sync-word edge detection and per-field line statistics.
// Rev 1.0
// ---------------------------------------------------------------------------
module n64_vinfo_lines
  import n64_vinfo_deblur_pkg::*;
#(
  parameter int PAL_LINES_MIN = 300
) (
  input  logic nCLK,
  input  logic nRST,
  input  logic nDSYNC,
  input  logic nvsync_i,
  input  logic nhsync_i,
  output logic vs_fall_o,
  output logic hs_fall_o,
  output logic n64_480i_d_o,
  output logic vmode_o,
  output logic n64_480i_o
);

  logic                  nvsync_prev_q;
  logic                  nhsync_prev_q;
  logic [LINE_CNT_W-1:0] line_cnt_q;
  logic [LINE_CNT_W-1:0] line_cnt_prev_q;
  logic [LINE_CNT_W-1:0] line_cnt_d;
  logic                  vmode_q;
  logic                  n64_480i_q;

  assign vs_fall_o = ~nDSYNC & nvsync_prev_q & ~nvsync_i;
  assign hs_fall_o = ~nDSYNC & nhsync_prev_q & ~nhsync_i;

  // A line starting on the vsync word is counted before the field is judged
  assign line_cnt_d   = line_cnt_q + LINE_CNT_W'(hs_fall_o);
  assign n64_480i_d_o = (line_cnt_d != line_cnt_prev_q);

  always_ff @(negedge nCLK) begin
    if (!nRST) begin
      nvsync_prev_q   <= 1'b1;
      nhsync_prev_q   <= 1'b1;
      line_cnt_q      <= '0;
      line_cnt_prev_q <= '0;
      vmode_q         <= 1'b0;
      n64_480i_q      <= 1'b0;
    end else if (!nDSYNC) begin
      nvsync_prev_q <= nvsync_i;
      nhsync_prev_q <= nhsync_i;
      if (vs_fall_o) begin
        vmode_q         <= (line_cnt_d >= LINE_CNT_W'(PAL_LINES_MIN));
        n64_480i_q      <= n64_480i_d_o;
        line_cnt_prev_q <= line_cnt_d;
        line_cnt_q      <= '0;
      end else begin
        line_cnt_q <= line_cnt_d;
      end
    end
  end

  assign vmode_o    = vmode_q;
  assign n64_480i_o = n64_480i_q;

endmodule
`default_nettype wire

// File: rtl/n64_vinfo_deblur.sv
`default_nettype none
// ---------------------------------------------------------------------------
// n64_vinfo_deblur: demux phase, video mode and auto-deblur decisions for n64_vdemux.
// Rev 1.0
// ---------------------------------------------------------------------------
module n64_vinfo_deblur
  import n64_vinfo_deblur_pkg::*;
#(
  parameter int DIFF_W        = 16,
  parameter int PAL_LINES_MIN = 300,
  parameter int HYST_FRAMES   = 2
) (
  input  logic       nCLK,
  input  logic       nRST,
  input  logic       nDSYNC,
  input  logic [6:0] D_i,
  input  logic [1:0] deblur_mode_i,
  input  logic       n15bit_mode_i,
  output logic [4:0] demuxparams_o,
  output logic       vmode_o,
  output logic       n64_480i_o
);

  localparam int                HYST_W    = (HYST_FRAMES > 1) ? $clog2(HYST_FRAMES) : 1;
  localparam logic [HYST_W-1:0] HYST_LAST = HYST_W'(HYST_FRAMES - 1);
  localparam logic [DIFF_W-1:0] DIFF_MAX  = '1;

  logic [1:0]        data_cnt_q;
  pixel_t            cur_px_q;
  pixel_t            prev_px_q;
  logic              nblank_q;
  logic              ndo_deblur_q;
  logic              ndo_deblur_d;
  logic              n15bit_q;
  logic [DIFF_W-1:0] nd_odd_q;
  logic [DIFF_W-1:0] nd_even_q;
  logic              auto_deblur_q;
  logic              auto_deblur_d;
  logic [HYST_W-1:0] hyst_cnt_q;
  logic [HYST_W-1:0] hyst_cnt_d;
  logic              vs_fall;
  logic              hs_fall;
  logic              n64_480i_d;
  logic              lowres;

  n64_vinfo_lines #(
    .PAL_LINES_MIN(PAL_LINES_MIN)
  ) u_lines (
    .nCLK        (nCLK),
    .nRST        (nRST),
    .nDSYNC      (nDSYNC),
    .nvsync_i    (D_i[3]),
    .nhsync_i    (D_i[1]),
    .vs_fall_o   (vs_fall),
    .hs_fall_o   (hs_fall),
    .n64_480i_d_o(n64_480i_d),
    .vmode_o     (vmode_o),
    .n64_480i_o  (n64_480i_o)
  );

  // Low-res content repeats each pixel, so odd-slot differences stay rare
  assign lowres = (nd_odd_q < (nd_even_q >> 2));

  always_comb begin
    auto_deblur_d = auto_deblur_q;
    hyst_cnt_d    = '0;
    if (lowres != auto_deblur_q) begin
      if (hyst_cnt_q >= HYST_LAST) auto_deblur_d = lowres;
      else                         hyst_cnt_d    = hyst_cnt_q + HYST_W'(1);
    end
    ndo_deblur_d = ~(~n64_480i_d &
                     ((deblur_mode_i == DEBLUR_MODE_ON) | (~deblur_mode_i[0] & auto_deblur_d)));
  end

  always_ff @(negedge nCLK) begin
    if (!nRST) begin
      data_cnt_q    <= 2'b00;
      cur_px_q      <= '0;
      prev_px_q     <= '0;
      nblank_q      <= 1'b1;
      ndo_deblur_q  <= 1'b1;
      n15bit_q      <= 1'b1;
      nd_odd_q      <= '0;
      nd_even_q     <= '0;
      auto_deblur_q <= 1'b0;
      hyst_cnt_q    <= '0;
    end else if (nDSYNC) begin
      data_cnt_q <= data_cnt_q + 2'd1;
      case (data_cnt_q)
        2'b01:   cur_px_q.r <= D_i;
        2'b10:   cur_px_q.g <= D_i;
        2'b11:   cur_px_q.b <= D_i;
        default: ;
      endcase
    end else begin
      data_cnt_q <= 2'b01;
      prev_px_q  <= cur_px_q;
      nblank_q   <= (ndo_deblur_q | hs_fall) ? 1'b1 : ~nblank_q;
      if (vs_fall) begin
        nd_odd_q      <= '0;
        nd_even_q     <= '0;
        auto_deblur_q <= auto_deblur_d;
        hyst_cnt_q    <= hyst_cnt_d;
        ndo_deblur_q  <= ndo_deblur_d;
        n15bit_q      <= n15bit_mode_i;
      end else if (D_i[2] && (cur_px_q != prev_px_q)) begin
        if (nblank_q) begin
          if (nd_even_q != DIFF_MAX) nd_even_q <= nd_even_q + DIFF_W'(1);
        end else begin
          if (nd_odd_q != DIFF_MAX) nd_odd_q <= nd_odd_q + DIFF_W'(1);
        end
      end
    end
  end

  always_comb begin
    demuxparams_o                          = '0;
    demuxparams_o[DMX_CNT_MSB:DMX_CNT_LSB] = data_cnt_q;
    demuxparams_o[DMX_NDEBLUR]             = ndo_deblur_q;
    demuxparams_o[DMX_NBLANK]              = nblank_q;
    demuxparams_o[DMX_N15BIT]              = n15bit_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_n64_vinfo_deblur.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_n64_vinfo_deblur: directed self-checking bench for n64_vinfo_deblur.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_n64_vinfo_deblur;

  logic       nCLK = 1'b0;
  logic       nRST = 1'b0;
  logic       nDSYNC = 1'b1;
  logic [6:0] D_i = '0;
  logic [1:0] deblur_mode_i = 2'b00;
  logic       n15bit_mode_i = 1'b1;
  logic [4:0] demuxparams_o;
  logic       vmode_o;
  logic       n64_480i_o;

  int tests = 0;
  int fails = 0;

  always #5 nCLK = ~nCLK;

  n64_vinfo_deblur #(
    .DIFF_W(16),
    .PAL_LINES_MIN(300),
    .HYST_FRAMES(2)
  ) dut (
    .nCLK         (nCLK),
    .nRST         (nRST),
    .nDSYNC       (nDSYNC),
    .D_i          (D_i),
    .deblur_mode_i(deblur_mode_i),
    .n15bit_mode_i(n15bit_mode_i),
    .demuxparams_o(demuxparams_o),
    .vmode_o      (vmode_o),
    .n64_480i_o   (n64_480i_o)
  );

  // One bus word: driven after posedge, sampled by the DUT on negedge, settled at return
  task automatic send_word(input logic ds, input logic [6:0] d);
    @(posedge nCLK);
    nDSYNC = ds;
    D_i    = d;
    @(negedge nCLK);
    #1;
  endtask

  task automatic send_pixel(input logic nv, input logic clamp, input logic nh, input logic [6:0] r);
    send_word(1'b0, {3'b000, nv, clamp, nh, nv & nh});
    send_word(1'b1, r);
    send_word(1'b1, 7'd0);
    send_word(1'b1, 7'd0);
  endtask

  // pat 0: all-zero pixels, 1: identical pixel pairs, 2: every pixel distinct
  task automatic send_line(input int nslots, input bit vs, input int pat);
    logic [6:0] r;
    for (int s = 0; s < nslots; s++) begin
      if (pat == 1)      r = 7'((s >> 1) + 1);
      else if (pat == 2) r = 7'(s + 1);
      else               r = 7'd0;
      send_pixel(!(vs && s == 0), s != 0, s != 0, r);
    end
  endtask

  // vsync falls together with hsync at the start of the last line
  task automatic send_field(input int nlines, input int nslots, input int pat);
    for (int l = 0; l < nlines; l++) send_line(nslots, l == nlines - 1, pat);
  endtask

  task automatic do_reset();
    @(posedge nCLK);
    nRST   = 1'b0;
    nDSYNC = 1'b1;
    D_i    = '0;
    repeat (3) @(negedge nCLK);
    #1;
    @(posedge nCLK);
    nRST = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge nCLK);
    nRST   = 1'b0;
    nDSYNC = 1'b1;
    D_i    = '0;
    repeat (3) @(negedge nCLK);
    #1;
    tests++; if (demuxparams_o !== 5'b00111) begin fails++; $display("FAIL reset_dmx: got %b want 00111", demuxparams_o); end
    tests++; if (vmode_o !== 1'b0) begin fails++; $display("FAIL reset_vmode: got %b want 0", vmode_o); end
    tests++; if (n64_480i_o !== 1'b0) begin fails++; $display("FAIL reset_480i: got %b want 0", n64_480i_o); end
    @(posedge nCLK);
    nRST = 1'b1;
    send_word(1'b0, 7'b0001111);
    tests++; if (demuxparams_o !== 5'b01111) begin fails++; $display("FAIL phase_sync: got %b want 01111", demuxparams_o); end
    send_word(1'b1, 7'h11);
    tests++; if (demuxparams_o[4:3] !== 2'b10) begin fails++; $display("FAIL phase_r: got %b want 10", demuxparams_o[4:3]); end
    send_word(1'b1, 7'h22);
    tests++; if (demuxparams_o[4:3] !== 2'b11) begin fails++; $display("FAIL phase_g: got %b want 11", demuxparams_o[4:3]); end
    send_word(1'b1, 7'h33);
    tests++; if (demuxparams_o[4:3] !== 2'b00) begin fails++; $display("FAIL phase_b: got %b want 00", demuxparams_o[4:3]); end
    send_word(1'b1, 7'h00);
    tests++; if (demuxparams_o[4:3] !== 2'b01) begin fails++; $display("FAIL phase_nosync_wrap: got %b want 01", demuxparams_o[4:3]); end
  endtask

  task automatic test_vmode();
    int lines [7];
    bit exp_v [7];
    bit exp_i [7];
    lines = '{262, 262, 262, 312, 312, 300, 299};
    exp_v = '{0, 0, 0, 1, 1, 1, 0};
    exp_i = '{1, 0, 0, 1, 0, 1, 1};
    do_reset();
    deblur_mode_i = 2'b00;
    for (int f = 0; f < 7; f++) begin
      send_field(lines[f], 2, 0);
      tests++;
      if (vmode_o !== exp_v[f] || n64_480i_o !== exp_i[f] || demuxparams_o[2] !== 1'b1) begin
        fails++;
        $display("FAIL vmode_field%0d(%0d lines): vmode=%b 480i=%b ndeblur=%b want %b %b 1",
                 f, lines[f], vmode_o, n64_480i_o, demuxparams_o[2], exp_v[f], exp_i[f]);
      end
    end
  endtask

  task automatic test_interlace();
    int lines [5];
    bit exp_i [5];
    lines = '{262, 263, 262, 263, 263};
    exp_i = '{1, 1, 1, 1, 0};
    do_reset();
    deblur_mode_i = 2'b10;
    for (int f = 0; f < 5; f++) begin
      send_field(lines[f], 2, 0);
      // forced deblur only takes effect once the source is progressive
      tests++;
      if (n64_480i_o !== exp_i[f] || demuxparams_o[2] !== exp_i[f]) begin
        fails++;
        $display("FAIL interlace_field%0d: 480i=%b ndeblur=%b want %b %b",
                 f, n64_480i_o, demuxparams_o[2], exp_i[f], exp_i[f]);
      end
    end
    deblur_mode_i = 2'b00;
  endtask

  task automatic test_auto_deblur();
    do_reset();
    deblur_mode_i = 2'b00;
    send_field(8, 6, 1);
    tests++; if (demuxparams_o[2] !== 1'b1) begin fails++; $display("FAIL auto_field1: ndeblur=%b want 1", demuxparams_o[2]); end
    send_field(8, 6, 1);
    tests++; if (demuxparams_o[2] !== 1'b0 || n64_480i_o !== 1'b0) begin fails++; $display("FAIL auto_field2: ndeblur=%b 480i=%b want 0 0", demuxparams_o[2], n64_480i_o); end
    // first line of the next field, watching nblank after each sync word
    for (int s = 0; s < 6; s++) begin
      send_word(1'b0, {3'b000, 1'b1, s != 0, s != 0, s != 0});
      tests++;
      if (demuxparams_o[1] !== ((s % 2) == 0)) begin
        fails++;
        $display("FAIL nblank_slot%0d: got %b want %b", s, demuxparams_o[1], (s % 2) == 0);
      end
      send_word(1'b1, 7'((s >> 1) + 1));
      send_word(1'b1, 7'd0);
      send_word(1'b1, 7'd0);
    end
    send_field(7, 6, 1);
    tests++; if (demuxparams_o[2] !== 1'b0) begin fails++; $display("FAIL auto_hold: ndeblur=%b want 0", demuxparams_o[2]); end
    deblur_mode_i = 2'b01;
    send_field(8, 6, 1);
    tests++; if (demuxparams_o[2] !== 1'b1) begin fails++; $display("FAIL force_off: ndeblur=%b want 1", demuxparams_o[2]); end
    deblur_mode_i = 2'b00;
    send_field(8, 6, 1);
    tests++; if (demuxparams_o[2] !== 1'b0) begin fails++; $display("FAIL auto_resume: ndeblur=%b want 0", demuxparams_o[2]); end
  endtask

  // Continues from the locked state left by test_auto_deblur
  task automatic test_hysteresis();
    send_field(8, 6, 2);
    tests++; if (demuxparams_o[2] !== 1'b0) begin fails++; $display("FAIL hyst_one_random: ndeblur=%b want 0", demuxparams_o[2]); end
    send_field(8, 6, 1);
    tests++; if (demuxparams_o[2] !== 1'b0) begin fails++; $display("FAIL hyst_paired_again: ndeblur=%b want 0", demuxparams_o[2]); end
    send_field(8, 6, 2);
    tests++; if (demuxparams_o[2] !== 1'b0) begin fails++; $display("FAIL hyst_random1: ndeblur=%b want 0", demuxparams_o[2]); end
    send_field(8, 6, 2);
    tests++; if (demuxparams_o[2] !== 1'b1) begin fails++; $display("FAIL hyst_random2: ndeblur=%b want 1", demuxparams_o[2]); end
  endtask

  task automatic test_reset_mid_field();
    do_reset();
    n15bit_mode_i = 1'b0;
    send_field(312, 2, 0);
    tests++; if (vmode_o !== 1'b1 || n64_480i_o !== 1'b1 || demuxparams_o[0] !== 1'b0) begin fails++; $display("FAIL premid_state: vmode=%b 480i=%b n15=%b want 1 1 0", vmode_o, n64_480i_o, demuxparams_o[0]); end
    send_line(2, 1'b0, 0);
    send_line(2, 1'b0, 0);
    send_word(1'b0, 7'b0001111);
    send_word(1'b1, 7'd5);
    @(posedge nCLK);
    nRST   = 1'b0;
    nDSYNC = 1'b1;
    @(negedge nCLK);
    #1;
    tests++; if (demuxparams_o !== 5'b00111 || vmode_o !== 1'b0 || n64_480i_o !== 1'b0) begin fails++; $display("FAIL midreset: dmx=%b vmode=%b 480i=%b want 00111 0 0", demuxparams_o, vmode_o, n64_480i_o); end
    @(posedge nCLK);
    nRST = 1'b1;
    for (int l = 0; l < 3; l++) send_line(2, 1'b0, 0);
    tests++; if (demuxparams_o[0] !== 1'b1) begin fails++; $display("FAIL n15_hold_reset: got %b want 1", demuxparams_o[0]); end
    send_field(4, 2, 0);
    tests++; if (demuxparams_o[0] !== 1'b0) begin fails++; $display("FAIL n15_latch0: got %b want 0", demuxparams_o[0]); end
    n15bit_mode_i = 1'b1;
    send_line(2, 1'b0, 0);
    send_line(2, 1'b0, 0);
    tests++; if (demuxparams_o[0] !== 1'b0) begin fails++; $display("FAIL n15_hold_midfield: got %b want 0", demuxparams_o[0]); end
    send_field(4, 2, 0);
    tests++; if (demuxparams_o[0] !== 1'b1) begin fails++; $display("FAIL n15_latch1: got %b want 1", demuxparams_o[0]); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_vmode();
    test_interlace();
    test_auto_deblur();
    test_hysteresis();
    test_reset_mid_field();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
